// File: rtl/fsm_job_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : fsm_job_dispatcher
// Purpose  : Queues job IDs in a small FIFO, issues one start pulse per job to
//            a downstream FSM and reports a completion record per job.
//            Optional macro DISPATCH_TIMEOUT_EN forces completion after TIMEOUT.
// Revision : 1.0 - initial release
// ============================================================================
module fsm_job_dispatcher #(
  parameter int DEPTH   = 4,
  parameter int ID_W    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  input  logic [ID_W-1:0]            req_id,
  output logic                       req_ready,
  output logic                       start,
  input  logic                       fsm_busy,
  input  logic                       fsm_done,
  output logic                       cmp_valid,
  output logic [ID_W-1:0]            cmp_id,
  output logic                       cmp_timeout,
  output logic [$clog2(DEPTH+1)-1:0] queue_count,
  output logic                       in_flight
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_REPORT    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   mem_q [DEPTH];
  logic [ID_W-1:0]   mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic [ID_W-1:0]   cmp_id_q, cmp_id_d;
  logic              cmp_to_q, cmp_to_d;
  logic              in_flight_q, in_flight_d;
  logic              w_push;
  logic              w_pop;
  logic              w_tmr_expired;

  // Ready comes from the registered count only; a same-cycle pop does not make room.
  assign req_ready = (count_q < c_depth);
  assign w_push    = req_valid && req_ready;

`ifdef DISPATCH_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] c_tmr_last = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;

  always_comb begin
    tmr_d = tmr_q;
    if (state_q == ST_ISSUE) begin
      tmr_d = '0;
    end else if (state_q == ST_WAIT_DONE) begin
      tmr_d = tmr_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end

  assign w_tmr_expired = (tmr_q == c_tmr_last);
`else
  // No watchdog in this build: the comparison is constant false.
  assign w_tmr_expired = (TIMEOUT < 0);
`endif

  always_comb begin
    mem_d = mem_q;
    if (w_push) begin
      mem_d[wr_ptr_q] = req_id;
    end
  end

  always_comb begin
    wr_ptr_d = w_push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = w_pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    count_d  = count_q;
    if (w_push && !w_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    w_pop       = 1'b0;
    cur_id_d    = cur_id_q;
    cmp_id_d    = cmp_id_q;
    cmp_to_d    = cmp_to_q;
    in_flight_d = in_flight_q;
    case (state_q)
      ST_IDLE: begin
        if ((count_q != '0) && !fsm_busy) begin
          w_pop       = 1'b1;
          cur_id_d    = mem_q[rd_ptr_q];
          in_flight_d = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // A done arriving in the expiry cycle takes priority over the timeout.
        if (fsm_done) begin
          cmp_id_d = cur_id_q;
          cmp_to_d = 1'b0;
          state_d  = ST_REPORT;
        end else if (w_tmr_expired) begin
          cmp_id_d = cur_id_q;
          cmp_to_d = 1'b1;
          state_d  = ST_REPORT;
        end
      end
      ST_REPORT: begin
        in_flight_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cur_id_q    <= '0;
      cmp_id_q    <= '0;
      cmp_to_q    <= 1'b0;
      in_flight_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cur_id_q    <= cur_id_d;
      cmp_id_q    <= cmp_id_d;
      cmp_to_q    <= cmp_to_d;
      in_flight_q <= in_flight_d;
    end
  end

  assign start       = (state_q == ST_ISSUE);
  assign cmp_valid   = (state_q == ST_REPORT);
  assign cmp_id      = cmp_id_q;
  assign cmp_timeout = cmp_to_q;
  assign queue_count = count_q;
  assign in_flight   = in_flight_q;

endmodule
`default_nettype wire

// File: tb/tb_fsm_job_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsm_job_dispatcher
// Purpose  : Self-checking bench: vector table, directed corner sequences and
//            random traffic against a job-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsm_job_dispatcher;

  localparam int DEPTH   = 4;
  localparam int ID_W    = 4;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = $clog2(DEPTH + 1);
`ifdef DISPATCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic [ID_W-1:0]  req_id = '0;
  logic             fsm_busy = 1'b0;
  logic             fsm_done = 1'b0;
  logic             req_ready;
  logic             start;
  logic             cmp_valid;
  logic [ID_W-1:0]  cmp_id;
  logic             cmp_timeout;
  logic [CNT_W-1:0] queue_count;
  logic             in_flight;

  always #5 clk = ~clk;

  fsm_job_dispatcher #(.DEPTH(DEPTH), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_id(req_id), .req_ready(req_ready),
    .start(start), .fsm_busy(fsm_busy), .fsm_done(fsm_done),
    .cmp_valid(cmp_valid), .cmp_id(cmp_id), .cmp_timeout(cmp_timeout),
    .queue_count(queue_count), .in_flight(in_flight)
  );

  int errors = 0;
  int checks = 0;

  // Job-level reference: waiting IDs in a queue, one job's lifecycle tracked
  // by its age in cycles since it was popped.
  int              m_q[$];
  bit              m_act;
  bit              m_rep;
  int              m_age;
  logic [ID_W-1:0] m_cur;
  logic [ID_W-1:0] m_last_id;
  bit              m_last_to;
  int              cmp_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_act = 1'b0; m_rep = 1'b0; m_age = 0;
    m_cur = '0; m_last_id = '0; m_last_to = 1'b0;
  endfunction

  function automatic logic [11:0] model_outs();
    return {m_act && (m_age == 0), m_act && m_rep, m_last_id, m_last_to,
            CNT_W'(m_q.size()), m_q.size() < DEPTH, m_act};
  endfunction

  function automatic void model_update(bit rst, bit rv, logic [ID_W-1:0] rid, bit busy, bit done);
    bit push;
    if (rst) begin
      model_reset();
      return;
    end
    push = rv && (m_q.size() < DEPTH);
    if (m_act) begin
      if (m_rep) begin
        m_act = 1'b0; m_rep = 1'b0;
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (done) begin
        m_rep = 1'b1; m_last_id = m_cur; m_last_to = 1'b0;
      end else if (TO_EN && (m_age - 1 == TIMEOUT - 1)) begin
        m_rep = 1'b1; m_last_id = m_cur; m_last_to = 1'b1;
      end else begin
        m_age++;
      end
    end else if (m_q.size() != 0 && !busy) begin
      m_cur = ID_W'(m_q.pop_front());
      m_act = 1'b1; m_age = 0; m_rep = 1'b0;
    end
    if (push) m_q.push_back(int'(rid));
  endfunction

  // Called just after a falling edge: check, drive, clock, update model.
  task automatic step(input bit rst, input bit rv, input logic [ID_W-1:0] rid,
                      input bit busy, input bit done);
    chk("cycle_outputs",
        {20'd0, start, cmp_valid, cmp_id, cmp_timeout, queue_count, req_ready, in_flight},
        {20'd0, model_outs()});
    if (cmp_valid === 1'b1) cmp_log.push_back(int'(cmp_id));
    reset = rst; req_valid = rv; req_id = rid; fsm_busy = busy; fsm_done = done;
    @(posedge clk);
    model_update(rst, rv, rid, busy, done);
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((m_act || m_q.size() != 0) && n < budget) begin
      step(0, 0, '0, 0, 1);
      n++;
    end
    chk("drain_finished", {30'd0, m_act, m_q.size() != 0}, 32'd0);
  endtask

  typedef struct {
    bit rv; logic [ID_W-1:0] rid; bit busy; bit done;
    bit e_start; bit e_cv; logic [ID_W-1:0] e_id; bit e_to; int e_qc; bit e_rdy; bit e_inf;
  } vec_t;

  function automatic vec_t mk(bit rv, logic [ID_W-1:0] rid, bit busy, bit done, bit st, bit cv,
                              logic [ID_W-1:0] id, bit to, int qc, bit rdy, bit inf);
    vec_t v;
    v.rv = rv; v.rid = rid; v.busy = busy; v.done = done;
    v.e_start = st; v.e_cv = cv; v.e_id = id; v.e_to = to; v.e_qc = qc; v.e_rdy = rdy; v.e_inf = inf;
    return v;
  endfunction

  initial begin
    vec_t tbl[16];
    int   idx, guard, s_cyc, c_cyc, ncv, full_cycles;
    bit   saw_full, c_to;
    logic [ID_W-1:0] c_id;

    // Single job with ID 5 (done two cycles after start), then ID 7 held off by busy.
    tbl[0]  = mk(1, 4'h5, 0, 0,  0, 0, 4'h0, 0, 0, 1, 0);
    tbl[1]  = mk(0, 4'h0, 0, 0,  0, 0, 4'h0, 0, 1, 1, 0);
    tbl[2]  = mk(0, 4'h0, 0, 0,  1, 0, 4'h0, 0, 0, 1, 1);
    tbl[3]  = mk(0, 4'h0, 0, 0,  0, 0, 4'h0, 0, 0, 1, 1);
    tbl[4]  = mk(0, 4'h0, 0, 1,  0, 0, 4'h0, 0, 0, 1, 1);
    tbl[5]  = mk(0, 4'h0, 0, 0,  0, 1, 4'h5, 0, 0, 1, 1);
    tbl[6]  = mk(0, 4'h0, 0, 0,  0, 0, 4'h5, 0, 0, 1, 0);
    tbl[7]  = mk(0, 4'h0, 0, 1,  0, 0, 4'h5, 0, 0, 1, 0);
    tbl[8]  = mk(1, 4'h7, 1, 0,  0, 0, 4'h5, 0, 0, 1, 0);
    tbl[9]  = mk(0, 4'h0, 1, 0,  0, 0, 4'h5, 0, 1, 1, 0);
    tbl[10] = mk(0, 4'h0, 1, 1,  0, 0, 4'h5, 0, 1, 1, 0);
    tbl[11] = mk(0, 4'h0, 0, 0,  0, 0, 4'h5, 0, 1, 1, 0);
    tbl[12] = mk(0, 4'h0, 0, 0,  1, 0, 4'h5, 0, 0, 1, 1);
    tbl[13] = mk(0, 4'h0, 0, 1,  0, 0, 4'h5, 0, 0, 1, 1);
    tbl[14] = mk(0, 4'h0, 0, 0,  0, 1, 4'h7, 0, 0, 1, 1);
    tbl[15] = mk(0, 4'h0, 0, 0,  0, 0, 4'h7, 0, 0, 1, 0);

    reset = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      chk($sformatf("vec%0d", i),
          {21'd0, start, cmp_valid, cmp_id, cmp_timeout, queue_count, req_ready, in_flight},
          {21'd0, tbl[i].e_start, tbl[i].e_cv, tbl[i].e_id, tbl[i].e_to,
           CNT_W'(tbl[i].e_qc), tbl[i].e_rdy, tbl[i].e_inf});
      step(0, tbl[i].rv, tbl[i].rid, tbl[i].busy, tbl[i].done);
    end

    // Fill past DEPTH with the FSM stalled; ID 5 must wait for room.
    cmp_log.delete();
    idx = 0; guard = 0; saw_full = 0; full_cycles = 0;
    while (idx < 5 && guard < 60) begin
      if (m_q.size() >= DEPTH) begin
        saw_full = 1; full_cycles++;
      end
      if (m_q.size() < DEPTH) begin
        step(0, 1, ID_W'(idx + 1), full_cycles < 3, 0);
        idx++;
      end else begin
        step(0, 1, ID_W'(idx + 1), full_cycles < 3, 0);
      end
      guard++;
    end
    chk("fill_all_pushed", idx, 5);
    chk("fill_saw_full", {31'd0, saw_full}, 32'd1);
    guard = 0;
    while (cmp_log.size() < 5 && guard < 300) begin
      step(0, 0, '0, 0, ($urandom % 3) == 0);
      guard++;
    end
    chk("fill_cmp_count", cmp_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < cmp_log.size()) chk($sformatf("fill_order%0d", i), cmp_log[i], i + 1);
    end
    drain(50);

    // Reset while a job is waiting for done and two more are queued.
    step(0, 1, 4'hA, 0, 0);
    step(0, 1, 4'hB, 0, 0);
    step(0, 1, 4'hC, 0, 0);
    step(0, 0, '0, 0, 0);
    step(1, 0, '0, 0, 0);
    chk("rst_queue_count", queue_count, 0);
    chk("rst_in_flight", in_flight, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_cmp_id", cmp_id, 0);
    cmp_log.delete();
    for (int i = 0; i < 12; i++) step(0, 0, '0, 0, 1);
    chk("rst_no_completion", cmp_log.size(), 0);

    // Watchdog behaviour (or its absence).
    s_cyc = -1; c_cyc = -1; c_to = 0; c_id = '0;
    step(0, 1, 4'h9, 0, 0);
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (start === 1'b1 && s_cyc < 0) s_cyc = cyc;
      if (cmp_valid === 1'b1 && c_cyc < 0) begin
        c_cyc = cyc; c_to = cmp_timeout; c_id = cmp_id;
      end
      step(0, 0, '0, 0, 0);
    end
`ifdef DISPATCH_TIMEOUT_EN
    chk("to_latency", c_cyc - s_cyc, 17);
    chk("to_flag", {31'd0, c_to}, 1);
    chk("to_id", c_id, 4'h9);
    s_cyc = -1; c_cyc = -1; c_to = 1;
    step(0, 1, 4'h6, 0, 0);
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (start === 1'b1 && s_cyc < 0) s_cyc = cyc;
      if (cmp_valid === 1'b1 && c_cyc < 0) begin
        c_cyc = cyc; c_to = cmp_timeout; c_id = cmp_id;
      end
      step(0, 0, '0, 0, (s_cyc >= 0) && (cyc == s_cyc + 16));
    end
    chk("done_wins_latency", c_cyc - s_cyc, 17);
    chk("done_wins_flag", {31'd0, c_to}, 0);
    chk("done_wins_id", c_id, 4'h6);
`else
    chk("no_to_completion", c_cyc, -1);
    chk("no_to_started", {31'd0, s_cyc >= 0}, 1);
    ncv = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (cmp_valid === 1'b1) begin
        ncv++; c_to = cmp_timeout; c_id = cmp_id;
      end
      step(0, 0, '0, 0, 1);
    end
    chk("late_done_count", ncv, 1);
    chk("late_done_flag", {31'd0, c_to}, 0);
    chk("late_done_id", c_id, 4'h9);
`endif
    drain(50);

    // Push and pop on the same edge at count 2, then stream IDs across the pointer wrap.
    cmp_log.delete();
    step(0, 1, 4'd1, 1, 0);
    step(0, 1, 4'd2, 1, 0);
    chk("pp_before", queue_count, 2);
    step(0, 1, 4'd3, 0, 0);
    chk("pp_after", queue_count, 2);
    idx = 4; guard = 0;
    while ((idx <= 10 || cmp_log.size() < 10) && guard < 400) begin
      if (idx <= 10 && m_q.size() < DEPTH) begin
        step(0, 1, ID_W'(idx), 0, $urandom % 2);
        idx++;
      end else begin
        step(0, idx <= 10, ID_W'(idx), 0, $urandom % 2);
      end
      guard++;
    end
    chk("wrap_cmp_count", cmp_log.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < cmp_log.size()) chk($sformatf("wrap_order%0d", i), cmp_log[i], i + 1);
    end
    drain(50);

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 300) == 0, $urandom % 2, ID_W'($urandom), ($urandom % 4) == 0,
           ($urandom % 6) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fsm_job_dispatcher.md
Name: fsm_job_dispatcher

Overview:
Upstream feeder for simple_fsm. Buffers incoming job requests, each carrying an ID, in a small FIFO. When the FSM is idle, it pops one job and drives a single-cycle `start` pulse. It then tracks the job until the FSM's `done` and reports a completion record carrying the job ID.

Parameters:
DEPTH, 4, job FIFO entries; power of two, minimum 2
ID_W, 4, job ID width
TIMEOUT, 16, cycles from `start` to forced completion; used only with the optional feature

Ports:
clk  in  1  single clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  job request present
req_id  in  ID_W  job ID
req_ready  out  1  FIFO can accept a job this cycle
start  out  1  one-cycle pulse to the FSM's `start` input
fsm_busy  in  1  from the FSM's `busy` output
fsm_done  in  1  from the FSM's `done` output
cmp_valid  out  1  one-cycle completion pulse
cmp_id  out  ID_W  ID of the completed job; valid with `cmp_valid`
cmp_timeout  out  1  completion was forced by timeout; valid with `cmp_valid`
queue_count  out  $clog2(DEPTH+1)  jobs waiting in the FIFO (excludes the in-flight job)
in_flight  out  1  a job has been issued and is not yet completed

Behaviour:
- Reset, applied at any clock edge, mid-job included:
  - all outputs go to 0 except `req_ready`, which goes to 1.
  - FIFO is emptied.
  - FSM returns to IDLE.
  - the in-flight job is discarded with no completion pulse.
- FIFO push:
  - a push occurs when `req_valid` and `req_ready` are both high.
  - `req_ready` = (`queue_count` < DEPTH), computed from registered count; there is no same-cycle full bypass.
  - a push and a pop in the same cycle leave the count unchanged.
  - `req_valid` while full is ignored; the requester must hold its request.
- Pointers: read and write pointers are log2(DEPTH) bits wide and wrap naturally.
- FIFO pop: only in IDLE, with `queue_count` != 0.
- State machine, registered, 4 states:
  - IDLE:
    - condition is `queue_count` != 0 and `fsm_busy` = 0.
    - action: pop the head into `cur_id`, set `in_flight` = 1, go to ISSUE.
    - otherwise stay in IDLE.
  - ISSUE:
    - `start` = 1 for exactly this one cycle (Moore output).
    - always goes to WAIT_DONE.
  - WAIT_DONE:
    - on `fsm_done` = 1: go to REPORT with timeout flag = 0.
    - otherwise stay in WAIT_DONE.
    - `fsm_busy` is informational only.
  - REPORT:
    - `cmp_valid` = 1, `cmp_id` = `cur_id`, `cmp_timeout` = flag.
    - clear `in_flight`, go to IDLE.
  - Any unreachable encoding goes to IDLE.
- Latency:
  - request accepted at edge T with the block idle and the FIFO empty → `start` high in the cycle after edge T+1.
  - `fsm_done` sampled at edge D → `cmp_valid` high in the cycle after edge D.
- Back-to-back jobs:
  - after REPORT, IDLE may pop on the next edge.
  - minimum spacing between `start` pulses = FSM job length + 3 cycles.
- `fsm_busy` high in IDLE:
  - the pop is blocked; this guards against a start while the FSM is still RUNNING.
  - the FIFO still accepts pushes.
- `fsm_done` outside WAIT_DONE is ignored.
- Each accepted job produces exactly one `cmp_valid` pulse, in FIFO order, unless reset intervenes.
- `cmp_id` and `cmp_timeout` hold their last values while `cmp_valid` = 0.

Optional Feature:
DISPATCH_TIMEOUT_EN
- Defined:
  - a counter of $clog2(TIMEOUT+1) bits clears in ISSUE and increments every cycle in WAIT_DONE.
  - if the counter reaches TIMEOUT-1 with `fsm_done` = 0, go to REPORT with `cmp_timeout` = 1.
  - if `fsm_done` arrives in that same cycle, `done` wins and `cmp_timeout` = 0.
- Not defined:
  - no counter is built and `cmp_timeout` is tied to 0.
  - WAIT_DONE waits indefinitely.

Test Plan:
1. Reset held 2 cycles, then one request with `req_id` = 0x5; FSM model asserts `done` 2 cycles after `start` → `start` pulses once, 2 clocks after acceptance; one completion with `cmp_valid` = 1, `cmp_id` = 0x5, `cmp_timeout` = 0.
2. Push IDs 1,2,3,4,5 on consecutive cycles with DEPTH = 4 and the FSM model stalled → `req_ready` drops after the FIFO fills, ID 5 is held until space frees; completions arrive in order 1,2,3,4,5, each exactly once.
3. `fsm_busy` forced high with the FIFO holding ID 0x7 → no `start` while busy; `start` occurs 1 cycle after busy falls (IDLE pop edge, then ISSUE).
4. Reset asserted in WAIT_DONE with 2 jobs queued → next cycle `queue_count` = 0, `in_flight` = 0, `req_ready` = 1; no `cmp_valid` for the dropped jobs.
5. With DISPATCH_TIMEOUT_EN and TIMEOUT = 16, `fsm_done` never asserted → `cmp_valid` with `cmp_timeout` = 1 arrives 17 cycles after the `start` cycle; with `done` in the terminal cycle → `cmp_timeout` = 0.
6. Simultaneous push and pop at `queue_count` = 2 → `queue_count` stays 2 and the FIFO order is preserved across pointer wrap (push 10 IDs through DEPTH = 4).
